// File: rtl/mem_stage_ctrl_if.sv
// Data memory bus between the memory stage and the data RAM.
// Read data is combinational from the address.
interface mem_stage_ctrl_if;
  logic [31:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [15:0] mem_rdata;

  modport master (
    output mem_addr, mem_wdata, mem_we, mem_re,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_we, mem_re,
    output mem_rdata
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// Memory stage: data memory access, stack pointer and
// multi-cycle PC/flag push and pop sequencing.
module mem_stage_ctrl #(
  parameter int          MemSize  = 9,
  parameter int          WbSize   = 2,
  parameter int          flagSize = 4,
  parameter logic [31:0] SP_INIT  = 32'h0000_07FF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [MemSize-1:0]  i_Mem,
  input  logic [WbSize-1:0]   i_WB,
  input  logic [31:0]         i_pc,
  input  logic [2:0]          i_Rdst,
  input  logic [15:0]         i_alu,
  input  logic [15:0]         i_read_data1,
  input  logic [flagSize-1:0] i_flag,
  mem_stage_ctrl_if.master    mem_bus,
  output logic                o_stall,
  output logic [WbSize-1:0]   o_WB,
  output logic [2:0]          o_Rdst,
  output logic [15:0]         o_result,
  output logic [31:0]         o_pc_ret,
  output logic                o_pc_load,
  output logic [flagSize-1:0] o_flag_ret,
  output logic                o_flag_load,
  output logic [31:0]         o_sp
);

  typedef enum logic [1:0] {IDLE, W1, W2} state_t;

  state_t              state, state_nx;
  logic [31:0]         sp, sp_nx;
  logic [15:0]         hold, hold_nx;
  logic [flagSize-1:0] fhold, fhold_nx;
  logic                kill;

  logic rd, wr, push, pop, pcd, fs, fr, bad;
  logic unused_bits;

  assign rd   = i_Mem[0];
  assign wr   = i_Mem[1];
  assign push = i_Mem[2];
  assign pop  = i_Mem[3];
  assign pcd  = i_Mem[4];
  assign fs   = i_Mem[5];
  assign fr   = i_Mem[6];
  assign bad  = (push & pop) | (wr & pop);
  assign unused_bits = ^i_Mem[MemSize-1:7];

  assign o_sp = sp;

  // State, stack pointer and pop holding registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sp    <= SP_INIT;
      hold  <= '0;
      fhold <= '0;
    end else begin
      state <= state_nx;
      sp    <= sp_nx;
      hold  <= hold_nx;
      fhold <= fhold_nx;
    end
  end

  // Sequencing, memory bus drive and stage outputs
  always_comb begin
    state_nx          = state;
    sp_nx             = sp;
    hold_nx           = hold;
    fhold_nx          = fhold;
    mem_bus.mem_addr  = {16'b0, i_alu};
    mem_bus.mem_wdata = i_read_data1;
    mem_bus.mem_we    = 1'b0;
    mem_bus.mem_re    = 1'b0;
    o_stall           = 1'b0;
    o_result          = i_alu;
    o_pc_ret          = '0;
    o_pc_load         = 1'b0;
    o_flag_ret        = '0;
    o_flag_load       = 1'b0;
    kill              = 1'b0;
    if (rst) begin
      mem_bus.mem_addr  = '0;
      mem_bus.mem_wdata = '0;
      o_result          = '0;
      kill              = 1'b1;
    end else if (bad) begin
      kill     = 1'b1;
      state_nx = IDLE;
    end else if (push && !pcd) begin
      mem_bus.mem_addr = sp;
      mem_bus.mem_we   = 1'b1;
      sp_nx            = sp - 32'd1;
      state_nx         = IDLE;
    end else if (pop && !pcd) begin
      mem_bus.mem_addr = sp + 32'd1;
      mem_bus.mem_re   = 1'b1;
      o_result         = mem_bus.mem_rdata;
      sp_nx            = sp + 32'd1;
      state_nx         = IDLE;
    end else if (push) begin
      mem_bus.mem_addr = sp;
      mem_bus.mem_we   = 1'b1;
      sp_nx            = sp - 32'd1;
      unique case (state)
        IDLE: begin
          mem_bus.mem_wdata = i_pc[31:16];
          o_stall           = 1'b1;
          state_nx          = W1;
        end
        W1: begin
          mem_bus.mem_wdata = i_pc[15:0];
          o_stall           = fs;
          state_nx          = fs ? W2 : IDLE;
        end
        default: begin
          mem_bus.mem_wdata = {{(16-flagSize){1'b0}}, i_flag};
          state_nx          = IDLE;
        end
      endcase
    end else if (pop) begin
      mem_bus.mem_addr = sp + 32'd1;
      mem_bus.mem_re   = 1'b1;
      o_result         = mem_bus.mem_rdata;
      sp_nx            = sp + 32'd1;
      unique case (state)
        IDLE: begin
          o_stall  = 1'b1;
          state_nx = W1;
          if (fr) fhold_nx = mem_bus.mem_rdata[flagSize-1:0];
          else    hold_nx  = mem_bus.mem_rdata;
        end
        W1: begin
          if (fr) begin
            hold_nx  = mem_bus.mem_rdata;
            o_stall  = 1'b1;
            state_nx = W2;
          end else begin
            o_pc_ret  = {mem_bus.mem_rdata, hold};
            o_pc_load = 1'b1;
            state_nx  = IDLE;
          end
        end
        default: begin
          o_pc_ret    = {mem_bus.mem_rdata, hold};
          o_pc_load   = 1'b1;
          o_flag_ret  = fhold;
          o_flag_load = 1'b1;
          state_nx    = IDLE;
        end
      endcase
    end else begin
      mem_bus.mem_we = wr;
      mem_bus.mem_re = rd;
      o_result       = rd ? mem_bus.mem_rdata : i_alu;
      state_nx       = IDLE;
    end
    o_WB   = (o_stall || kill) ? '0 : i_WB;
    o_Rdst = (o_stall || kill) ? '0 : i_Rdst;
  end

endmodule
